// File: rtl/model2_sched.sv
// Issue scheduler for the model2 predictor: round-robins row streams, keeps per-lane
// reconstructed history, and carries a lane/point tag alongside the predictor latency.
module model2_sched #(
  parameter int W       = 32,
  parameter int LANES   = 4,
  parameter int LW      = 2,
  parameter int LAT     = 36,
  parameter int ROW_LEN = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic [W-1:0]  m_proceed1,
  output logic [W-1:0]  m_proceed2,
  output logic [W-1:0]  m_proceed3,
  output logic [W-1:0]  m_data_in,
  output logic          res_valid,
  output logic [LW-1:0] res_lane,
  output logic          res_warm,
  output logic          res_last,
  input  logic          fb_valid,
  input  logic [LW-1:0] fb_lane,
  input  logic [W-1:0]  fb_data,
  output logic          err
);

  localparam int IW = $clog2(ROW_LEN);
  localparam int TW = LW + 3;
  localparam logic [IW-1:0] IDX_LAST  = IW'(ROW_LEN - 1);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  logic [LANES-1:0][W-1:0]  h1_q, h1_d, h2_q, h2_d, h3_q, h3_d;
  logic [LANES-1:0]         busy_q, busy_d, lastp_q, lastp_d;
  logic [LANES-1:0][IW-1:0] idx_q, idx_d;
  logic [LW-1:0]            cur_q, cur_d;
  logic [W-1:0]             mp1_q, mp1_d, mp2_q, mp2_d, mp3_q, mp3_d, mdi_q, mdi_d;
  // Tag layout: {valid, lane, warm, last}
  logic [LAT-1:0][TW-1:0]   tag_q, tag_d;
  logic [TW-1:0]            res_q;
  logic [TW-1:0]            tag_in_s;
  logic                     err_q, err_d;
  logic                     issue_s, warm_s, last_s;
  logic [IW-1:0]            cur_idx_s;

  assign cur_idx_s = idx_q[cur_q];
  assign issue_s   = in_valid && !busy_q[cur_q];
  assign warm_s    = cur_idx_s < IW'(3);
  assign last_s    = cur_idx_s == IDX_LAST;
  assign in_ready  = issue_s;

  // Next-state for lane history, issue bookkeeping and the tag shift register.
  always_comb begin
    h1_d    = h1_q;
    h2_d    = h2_q;
    h3_d    = h3_q;
    busy_d  = busy_q;
    lastp_d = lastp_q;
    idx_d   = idx_q;
    cur_d   = cur_q;
    mp1_d   = mp1_q;
    mp2_d   = mp2_q;
    mp3_d   = mp3_q;
    mdi_d   = mdi_q;
    err_d   = err_q;
    tag_in_s = '0;

    if (fb_valid) begin
      if (busy_q[fb_lane]) begin
        busy_d[fb_lane] = 1'b0;
        // A returning last point means the lane's next row starts from zero history.
        if (lastp_q[fb_lane]) begin
          h1_d[fb_lane]    = '0;
          h2_d[fb_lane]    = '0;
          h3_d[fb_lane]    = '0;
          lastp_d[fb_lane] = 1'b0;
        end else begin
          h1_d[fb_lane] = h2_q[fb_lane];
          h2_d[fb_lane] = h3_q[fb_lane];
          h3_d[fb_lane] = fb_data;
        end
      end else begin
        err_d = 1'b1;
      end
    end else begin
      err_d = err_q;
    end

    if (issue_s) begin
      mp1_d          = h1_q[cur_q];
      mp2_d          = h2_q[cur_q];
      mp3_d          = h3_q[cur_q];
      mdi_d          = in_data;
      busy_d[cur_q]  = 1'b1;
      lastp_d[cur_q] = last_s;
      idx_d[cur_q]   = last_s ? '0 : cur_idx_s + IW'(1);
      cur_d          = (cur_q == LANE_LAST) ? '0 : cur_q + LW'(1);
      tag_in_s       = {1'b1, cur_q, warm_s, last_s};
    end else begin
      tag_in_s = '0;
    end

    tag_d = {tag_q[LAT-2:0], tag_in_s};
  end

  // State registers; reset discards history, in-flight tags and the error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      busy_q  <= '0;
      lastp_q <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      mp1_q   <= '0;
      mp2_q   <= '0;
      mp3_q   <= '0;
      mdi_q   <= '0;
      tag_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
      busy_q  <= busy_d;
      lastp_q <= lastp_d;
      idx_q   <= idx_d;
      cur_q   <= cur_d;
      mp1_q   <= mp1_d;
      mp2_q   <= mp2_d;
      mp3_q   <= mp3_d;
      mdi_q   <= mdi_d;
      tag_q   <= tag_d;
      res_q   <= tag_q[LAT-1];
      err_q   <= err_d;
    end
  end

  assign m_proceed1 = mp1_q;
  assign m_proceed2 = mp2_q;
  assign m_proceed3 = mp3_q;
  assign m_data_in  = mdi_q;
  assign res_valid  = res_q[TW-1];
  assign res_lane   = res_q[TW-2 -: LW];
  assign res_warm   = res_q[1];
  assign res_last   = res_q[0];
  assign err        = err_q;

endmodule

// File: doc/model2_sched.md
# model2_sched

Issue scheduler for the 2nd-order predictor pipeline (`model2`, 36-cycle latency). It round-robins `LANES` independent row streams into the predictor so each lane's next point issues only after that lane's previous reconstructed value has returned. It keeps a three-deep history of reconstructed values per lane and drives the predictor's `proceed1/2/3` and `data_in` operands. It also carries a tag pipeline so the quantizer downstream knows which lane and point each prediction belongs to.

## Interface
- `W`, 32: data width; IEEE-754 single.
- `LANES`, 4: number of interleaved row streams; ≥2.
- `LW`, 2: lane index width; equals clog2(`LANES`).
- `LAT`, 36: predictor latency in cycles.
- `ROW_LEN`, 64: points per row; ≥4.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  input point available; points arrive in strict lane order 0,1,…,`LANES`-1,0,…
- `in_data`  in  `W`  original data value.
- `in_ready`  out  1  point accepted this cycle (combinational).
- `m_proceed1`  out  `W`  oldest history value, p[i-3].
- `m_proceed2`  out  `W`  history value p[i-2].
- `m_proceed3`  out  `W`  newest history value, p[i-1].
- `m_data_in`  out  `W`  original value to the predictor.
- `res_valid`  out  1  predictor outputs valid this cycle.
- `res_lane`  out  `LW`  lane of the current result.
- `res_warm`  out  1  point index < 3; prediction not meaningful.
- `res_last`  out  1  last point of its row.
- `fb_valid`  in  1  reconstructed value returning.
- `fb_lane`  in  `LW`  lane of the returning value.
- `fb_data`  in  `W`  reconstructed value.
- `err`  out  1  sticky protocol error.

## Operation
- Per-lane state:
  - `h1`, `h2`, `h3` (each `W`).
  - `busy` bit.
  - point counter `idx` (0..`ROW_LEN`-1).
  - `last_pend` bit.
- `cur` is the round-robin lane pointer.
- Issue condition: `in_valid` && !`busy[cur]`. `in_ready` equals this condition.
- On issue:
  - Register `m_proceed1/2/3` ← `h1/h2/h3[cur]` and `m_data_in` ← `in_data`.
  - Set `busy[cur]`.
  - `last_pend[cur]` ← (`idx`==`ROW_LEN`-1).
  - `idx` increments and wraps to 0 after `ROW_LEN`-1.
  - `cur` advances modulo `LANES`.
  - Push tag {valid=1, lane=`cur`, warm=(`idx`<3), last=(`idx`==`ROW_LEN`-1)} into the tag shift register.
- No issue:
  - `cur` holds; no lane is skipped.
  - `m_*` hold their values.
  - Push tag {valid=0}.
- On `fb_valid` with `busy[fb_lane]`=1:
  - Clear `busy`.
  - If `last_pend`=1: `h1/h2/h3` ← 0 (a new row starts from zero history) and clear `last_pend`.
  - Otherwise shift `h1`←`h2`, `h2`←`h3`, `h3`←`fb_data`.
- On `fb_valid` with `busy[fb_lane]`=0: no state change; set `err`. `err` is cleared only by reset.
- History updates use the raw bit pattern; the block does no arithmetic on data.

## Timing
- Reset state:
  - All `h`=0, `busy`=0, `idx`=0, `last_pend`=0, `cur`=0.
  - Tag pipeline flushed: `res_valid`=0, `res_lane`=0, `res_warm`=0, `res_last`=0.
  - `m_*`=0, `err`=0.
- An issue at edge t presents `m_*` from edge t. The tag emerges with `res_valid` high during the cycle starting at edge t+`LAT`.
- Tag pipeline is exactly `LAT` stages and free-running; it never stalls.
- Feedback/issue interaction:
  - A `fb_valid` sampled at edge t clears `busy` at t.
  - The lane is eligible for issue in the cycle after t; there is no same-cycle bypass.
  - History written at t is what that next issue reads.
- Simultaneous issue and feedback on different lanes: both take effect.
- Feedback on the lane being issued in the same cycle cannot occur, because `busy`=1 blocks that issue.
- Throughput: one point per cycle when the downstream round trip ≤ `LANES` cycles. Otherwise `in_ready` stalls on `busy[cur]`.
- Reset asserted mid-operation: everything clears immediately, in-flight tags are discarded, and late `fb_valid` after release sets `err`.

## Test plan
- Reset, then 4 points to lanes 0–3 with `in_valid` held high:
  - `in_ready`=1 for 4 cycles, then 0 at lane 0 (busy).
  - `res_valid` rises 36 cycles after the first issue with `res_lane`=0,1,2,3 and `res_warm`=1.
- Lane 0 fed back 1.0, 2.0, 4.0 (0x3F800000, 0x40000000, 0x40800000) on three round trips:
  - Fourth issue on lane 0 shows `m_proceed1`=0x3F800000, `m_proceed2`=0x40000000, `m_proceed3`=0x40800000, `res_warm`=0.
- `ROW_LEN`=4 on lane 1:
  - After feedback of the point with `res_last`=1, the next lane-1 issue shows all `m_proceed`=0 and `res_warm`=1.
- `fb_valid` on idle lane 2 → `err`=1 and lane 2 history unchanged; `err` stays 1 until reset.
- Lane 0 feedback and lane 3 issue in the same cycle:
  - Both update.
  - Lane 0 issues the following round with the new `h3`.
- Assert `rst` low mid-stream with 20 tags in flight:
  - `res_valid`=0 immediately and stays 0 for 36 cycles after release with no input.
  - `cur`=0.
